mod_counter_chain: RTL and testbench
====================================

# mod_counter_chain

Parametrised multi-digit modulo counter: NUM_DIGITS cascaded digits, each counting modulo MOD_VALUE, with up/down counting, synchronous clear and parallel load. It generalises the single-digit modulo counter for timer, scoreboard and display datapaths, for example a 3-digit BCD counter driving seven-segment logic. It also provides per-digit carry/borrow outputs and a sticky wrap flag for FSM-side consumers.

## Interface
Parameters:
- MOD_VALUE, default 10, modulus of every digit; legal range 2..2^DIGIT_WIDTH
- DIGIT_WIDTH, default 4, bits per digit
- NUM_DIGITS, default 3, number of cascaded digits; minimum 1

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- clear  input  1  synchronous clear of count and wrapped
- load  input  1  synchronous parallel load
- load_value  input  NUM_DIGITS*DIGIT_WIDTH  value to load; digit i in bits [i*DIGIT_WIDTH +: DIGIT_WIDTH]
- increment  input  1  count up one step
- decrement  input  1  count down one step
- count  output  NUM_DIGITS*DIGIT_WIDTH  registered count, same packing as load_value; digit 0 is least significant
- digit_carry  output  NUM_DIGITS  combinational; bit i = digit i wraps on this cycle's step
- rolling_over  output  1  combinational; whole counter wraps from max to 0 this cycle
- rolling_under  output  1  combinational; whole counter wraps from 0 to max this cycle
- wrapped  output  1  registered sticky flag; set on any full-counter wrap

## Operation
- Command priority, highest first: reset (async), clear, load, increment && decrement (no change), increment, decrement.
- Effective step:
  - up = increment && !decrement && !clear && !load
  - down = decrement && !increment && !clear && !load
- Up step: digit 0 advances by one.
  - Digit i at MOD_VALUE-1 wraps to 0 and carries into digit i+1.
  - Higher digits change only when all lower digits wrap.
- Down step: mirror of the up step. Digit at 0 wraps to MOD_VALUE-1 and borrows from the next digit.
- digit_carry[i] is asserted when either:
  - up is active and digits 0..i all equal MOD_VALUE-1, or
  - down is active and digits 0..i all equal 0.
- rolling_over = up && digit_carry[NUM_DIGITS-1].
- rolling_under = down && digit_carry[NUM_DIGITS-1].
- Load: each digit of load_value that is at least MOD_VALUE is clamped to MOD_VALUE-1. In-range digits load unchanged.
- Load has no effect on wrapped.
- wrapped:
  - Set at the edge where rolling_over or rolling_under is high.
  - Cleared only by clear or reset.
  - If clear and a wrap condition coincide, clear wins; the wrap cannot occur anyway, because clear masks up/down.
- Arithmetic per digit is DIGIT_WIDTH wide. No digit ever holds a value of MOD_VALUE or above.
- If MOD_VALUE equals 2^DIGIT_WIDTH, the wrap behaviour must still be exact; do not rely on natural overflow.
- Illegal parameters (MOD_VALUE < 2, MOD_VALUE > 2^DIGIT_WIDTH, NUM_DIGITS < 1) fail elaboration.

## Timing
- Reset values: count = 0 (all digits), wrapped = 0.
- digit_carry, rolling_over and rolling_under are 0 during reset because count is 0 and steps are masked... More precisely, they follow their combinational definitions, and the bench checks them only out of reset.
- reset asserted mid-count clears count and wrapped immediately, without waiting for clk.
- Deassertion is synchronised externally; the block needs no deassert filter.
- count updates at the rising clk edge after the command; latency is 1 cycle.
- Combinational outputs are valid in the same cycle as the inputs, based on the current count. They describe the transition that occurs at the next edge.
- wrapped rises 1 cycle after the cycle with rolling_over or rolling_under high.
- Continuous increment gives exactly MOD_VALUE^NUM_DIGITS cycles between rolling_over pulses. Each pulse is one cycle wide.
- No combinational path from load_value to any output.

## Test plan
- Reset and up-count (defaults): increment held high from 000 for 999 cycles -> count 999, rolling_over high, digit_carry = 3'b111. Next edge -> count 000 and wrapped = 1.
- Cascade carry: load 129 then increment -> digit_carry = 3'b001 before the edge, count 130 after it. Load 199 then increment -> digit_carry = 3'b011, count 200.
- Down count and underflow: clear, then decrement -> rolling_under high in that cycle, count 999 next cycle, wrapped set. A further decrement from 100 -> count 099.
- Priority and simultaneity:
  - increment && decrement at count 457 -> count stays 457 and all carries are 0.
  - load 321 with increment high -> count 321.
  - clear with load high -> count 000 and wrapped = 0.
- Load clamping: load_value digits {F,A,3} (hex) -> count {9,9,3}. Then increment -> count 994.
- Async reset mid-operation: reset pulsed between clk edges at count 642 with wrapped = 1 -> count 000 and wrapped = 0 before the next edge. Repeat with MOD_VALUE = 16, DIGIT_WIDTH = 4, NUM_DIGITS = 2: FF + increment -> 00 with rolling_over high.

Source files
------------

// File: rtl/mod_counter_chain.sv
// Cascaded multi-digit modulo counter with up/down stepping, clear, clamped parallel load,
// per-digit carry/borrow and a sticky full-counter wrap flag.
module mod_counter_chain #(
    parameter int unsigned MOD_VALUE   = 10,
    parameter int unsigned DIGIT_WIDTH = 4,
    parameter int unsigned NUM_DIGITS  = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              load,
    input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] load_value,
    input  logic                              increment,
    input  logic                              decrement,
    output logic [NUM_DIGITS*DIGIT_WIDTH-1:0] count,
    output logic [NUM_DIGITS-1:0]             digit_carry,
    output logic                              rolling_over,
    output logic                              rolling_under,
    output logic                              wrapped
);

    localparam int unsigned CountWidth = NUM_DIGITS * DIGIT_WIDTH;

    if (MOD_VALUE < 2 || longint'(MOD_VALUE) > (longint'(1) << DIGIT_WIDTH) || NUM_DIGITS < 1)
    begin : g_bad_params
        $error("mod_counter_chain: illegal MOD_VALUE/DIGIT_WIDTH/NUM_DIGITS");
    end

    localparam logic [DIGIT_WIDTH-1:0] MaxDigit = DIGIT_WIDTH'(MOD_VALUE - 1);
    localparam logic [DIGIT_WIDTH:0]   ModWide  = (DIGIT_WIDTH + 1)'(MOD_VALUE);

    logic [CountWidth-1:0]  r_count;
    logic                   r_wrapped;
    logic [CountWidth-1:0]  w_count_d;
    logic                   w_up;
    logic                   w_down;
    logic [NUM_DIGITS:0]    w_up_en;
    logic [NUM_DIGITS:0]    w_dn_en;
    logic [DIGIT_WIDTH-1:0] w_digit      [NUM_DIGITS];
    logic [DIGIT_WIDTH-1:0] w_load_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]  w_at_max;
    logic [NUM_DIGITS-1:0]  w_at_zero;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [DIGIT_WIDTH-1:0] w_ld_raw;
        assign w_digit[gi]   = r_count[gi*DIGIT_WIDTH +: DIGIT_WIDTH];
        assign w_ld_raw      = load_value[gi*DIGIT_WIDTH +: DIGIT_WIDTH];
        assign w_at_max[gi]  = (w_digit[gi] == MaxDigit);
        assign w_at_zero[gi] = (w_digit[gi] == '0);
        // Out-of-range load digits saturate to the largest legal digit.
        assign w_load_digit[gi] = ({1'b0, w_ld_raw} >= ModWide) ? MaxDigit : w_ld_raw;
    end

    assign w_up   = increment && !decrement && !clear && !load;
    assign w_down = decrement && !increment && !clear && !load;

    // w_up_en[i]/w_dn_en[i]: digit i steps this cycle; bit i+1 is digit i's carry/borrow out.
    always_comb begin
        w_up_en    = '0;
        w_dn_en    = '0;
        w_count_d  = r_count;
        w_up_en[0] = w_up;
        w_dn_en[0] = w_down;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_up_en[i+1] = w_up_en[i] && w_at_max[i];
            w_dn_en[i+1] = w_dn_en[i] && w_at_zero[i];
            if (clear) begin
                w_count_d[i*DIGIT_WIDTH +: DIGIT_WIDTH] = '0;
            end else if (load) begin
                w_count_d[i*DIGIT_WIDTH +: DIGIT_WIDTH] = w_load_digit[i];
            end else if (w_up_en[i]) begin
                w_count_d[i*DIGIT_WIDTH +: DIGIT_WIDTH] =
                    w_at_max[i] ? '0 : w_digit[i] + 1'b1;
            end else if (w_dn_en[i]) begin
                w_count_d[i*DIGIT_WIDTH +: DIGIT_WIDTH] =
                    w_at_zero[i] ? MaxDigit : w_digit[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_wrapped <= 1'b0;
        end else begin
            r_count <= w_count_d;
            if (clear) begin
                r_wrapped <= 1'b0;
            end else if (rolling_over || rolling_under) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    assign count         = r_count;
    assign wrapped       = r_wrapped;
    assign digit_carry   = w_up_en[NUM_DIGITS:1] | w_dn_en[NUM_DIGITS:1];
    assign rolling_over  = w_up_en[NUM_DIGITS];
    assign rolling_under = w_dn_en[NUM_DIGITS];

endmodule

// File: tb/tb_mod_counter_chain.sv
// Randomized self-checking bench for mod_counter_chain: a 3-digit decimal instance and a
// 2-digit hex instance, both checked against an integer-valued reference model.
module tb_mod_counter_chain;

    localparam int AMod = 10;
    localparam int ANd  = 3;
    localparam int AW   = 4;
    localparam int BMod = 16;
    localparam int BNd  = 2;
    localparam int BW   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                a_clear, a_load, a_inc, a_dec;
    logic [ANd*AW-1:0]   a_load_value, a_count;
    logic [ANd-1:0]      a_digit_carry;
    logic                a_rolling_over, a_rolling_under, a_wrapped;

    logic                b_clear, b_load, b_inc, b_dec;
    logic [BNd*BW-1:0]   b_load_value, b_count;
    logic [BNd-1:0]      b_digit_carry;
    logic                b_rolling_over, b_rolling_under, b_wrapped;

    mod_counter_chain #(.MOD_VALUE(AMod), .DIGIT_WIDTH(AW), .NUM_DIGITS(ANd)) u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .clear         (a_clear),
        .load          (a_load),
        .load_value    (a_load_value),
        .increment     (a_inc),
        .decrement     (a_dec),
        .count         (a_count),
        .digit_carry   (a_digit_carry),
        .rolling_over  (a_rolling_over),
        .rolling_under (a_rolling_under),
        .wrapped       (a_wrapped)
    );

    mod_counter_chain #(.MOD_VALUE(BMod), .DIGIT_WIDTH(BW), .NUM_DIGITS(BNd)) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .clear         (b_clear),
        .load          (b_load),
        .load_value    (b_load_value),
        .increment     (b_inc),
        .decrement     (b_dec),
        .count         (b_count),
        .digit_carry   (b_digit_carry),
        .rolling_over  (b_rolling_over),
        .rolling_under (b_rolling_under),
        .wrapped       (b_wrapped)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    longint m_val [2];
    bit     m_wr  [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int mod_of(input int k);
        return (k == 0) ? AMod : BMod;
    endfunction

    function automatic int nd_of(input int k);
        return (k == 0) ? ANd : BNd;
    endfunction

    function automatic int w_of(input int k);
        return (k == 0) ? AW : BW;
    endfunction

    function automatic longint total_of(input int k);
        longint t = 1;
        for (int i = 0; i < nd_of(k); i++) t = t * mod_of(k);
        return t;
    endfunction

    // Integer value -> packed digit vector.
    function automatic logic [63:0] to_vec(input longint v, input int k);
        logic [63:0] r = '0;
        longint      x = v;
        for (int i = 0; i < nd_of(k); i++) begin
            r = r | (64'(x % mod_of(k)) << (i * w_of(k)));
            x = x / mod_of(k);
        end
        return r;
    endfunction

    // Packed load vector -> integer value after per-digit saturation.
    function automatic longint load_val(input logic [63:0] lv, input int k);
        longint v = 0;
        longint d;
        for (int i = nd_of(k) - 1; i >= 0; i--) begin
            d = longint'((lv >> (i * w_of(k))) & ((64'd1 << w_of(k)) - 1));
            if (d >= mod_of(k)) d = mod_of(k) - 1;
            v = v * mod_of(k) + d;
        end
        return v;
    endfunction

    // Digit i carries when the low i+1 digits, read as a number, sit at their extreme.
    function automatic logic [63:0] carries(input longint v, input int k, input bit up,
                                            input bit dn);
        logic [63:0] c = '0;
        longint      p = 1;
        for (int i = 0; i < nd_of(k); i++) begin
            p = p * mod_of(k);
            if ((up && (v % p == p - 1)) || (dn && (v % p == 0))) c[i] = 1'b1;
        end
        return c;
    endfunction

    task automatic step(input int sel, input bit clr, input bit ld, input logic [63:0] lv,
                        input bit inc, input bit dec);
        bit          up [2];
        bit          dn [2];
        logic [63:0] got_dc, got_cnt;
        bit          got_ro, got_ru, got_wr;
        a_clear      = (sel == 0) && clr;
        a_load       = (sel == 0) && ld;
        a_inc        = (sel == 0) && inc;
        a_dec        = (sel == 0) && dec;
        a_load_value = (sel == 0) ? lv[ANd*AW-1:0] : '0;
        b_clear      = (sel == 1) && clr;
        b_load       = (sel == 1) && ld;
        b_inc        = (sel == 1) && inc;
        b_dec        = (sel == 1) && dec;
        b_load_value = (sel == 1) ? lv[BNd*BW-1:0] : '0;
        #1;
        for (int k = 0; k < 2; k++) begin
            up[k]  = (k == sel) && inc && !dec && !clr && !ld;
            dn[k]  = (k == sel) && dec && !inc && !clr && !ld;
            got_dc = (k == 0) ? 64'(a_digit_carry) : 64'(b_digit_carry);
            got_ro = (k == 0) ? a_rolling_over : b_rolling_over;
            got_ru = (k == 0) ? a_rolling_under : b_rolling_under;
            check_eq($sformatf("digit_carry[%0d]", k), got_dc, carries(m_val[k], k, up[k], dn[k]));
            check_eq($sformatf("rolling_over[%0d]", k), 64'(got_ro),
                     64'(up[k] && m_val[k] == total_of(k) - 1));
            check_eq($sformatf("rolling_under[%0d]", k), 64'(got_ru),
                     64'(dn[k] && m_val[k] == 0));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (k == sel && clr) begin
                m_val[k] = 0;
                m_wr[k]  = 1'b0;
            end else if (k == sel && ld) begin
                m_val[k] = load_val(lv, k);
            end else if (up[k]) begin
                if (m_val[k] == total_of(k) - 1) m_wr[k] = 1'b1;
                m_val[k] = (m_val[k] + 1) % total_of(k);
            end else if (dn[k]) begin
                if (m_val[k] == 0) m_wr[k] = 1'b1;
                m_val[k] = (m_val[k] + total_of(k) - 1) % total_of(k);
            end
            got_cnt = (k == 0) ? 64'(a_count) : 64'(b_count);
            got_wr  = (k == 0) ? a_wrapped : b_wrapped;
            check_eq($sformatf("count[%0d]", k), got_cnt, to_vec(m_val[k], k));
            check_eq($sformatf("wrapped[%0d]", k), 64'(got_wr), 64'(m_wr[k]));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, " count_a"}, 64'(a_count), 64'd0);
        check_eq({tag, " wrapped_a"}, 64'(a_wrapped), 64'd0);
        check_eq({tag, " count_b"}, 64'(b_count), 64'd0);
        check_eq({tag, " wrapped_b"}, 64'(b_wrapped), 64'd0);
    endtask

    // Reset is pulsed between edges; outputs must clear without a clock edge.
    task automatic async_reset_pulse();
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0;
            m_wr[k]  = 1'b0;
        end
    endtask

    initial begin
        bit          r_clr, r_ld, r_inc, r_dec;
        int          r_sel, r_pick;
        logic [63:0] r_lv;
        reset = 1'b1;
        {a_clear, a_load, a_inc, a_dec, b_clear, b_load, b_inc, b_dec} = '0;
        a_load_value = '0;
        b_load_value = '0;
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0;
            m_wr[k]  = 1'b0;
        end
        #12;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;

        // Full up-count to 999, then the wrapping step.
        for (int i = 0; i < 1000; i++) step(0, 0, 0, 64'h0, 1, 0);
        // Cascade carries.
        step(0, 0, 1, 64'h129, 0, 0);
        step(0, 0, 0, 64'h0, 1, 0);
        step(0, 0, 1, 64'h199, 0, 0);
        step(0, 0, 0, 64'h0, 1, 0);
        // Underflow and borrow.
        step(0, 1, 0, 64'h0, 0, 0);
        step(0, 0, 0, 64'h0, 0, 1);
        step(0, 0, 1, 64'h100, 0, 0);
        step(0, 0, 0, 64'h0, 0, 1);
        // Priority cases.
        step(0, 0, 1, 64'h457, 0, 0);
        step(0, 0, 0, 64'h0, 1, 1);
        step(0, 0, 1, 64'h321, 1, 0);
        step(0, 1, 1, 64'h555, 0, 0);
        // Load saturation.
        step(0, 0, 1, 64'hFA3, 0, 0);
        step(0, 0, 0, 64'h0, 1, 0);
        // Async reset at 642 with wrapped set.
        step(0, 0, 1, 64'h999, 0, 0);
        step(0, 0, 0, 64'h0, 1, 0);
        step(0, 0, 1, 64'h642, 0, 0);
        async_reset_pulse();
        // Power-of-two modulus: FF + increment.
        step(1, 0, 1, 64'hFF, 0, 0);
        step(1, 0, 0, 64'h0, 1, 0);
        step(1, 0, 0, 64'h0, 0, 1);
        step(1, 0, 0, 64'h0, 1, 0);

        for (int i = 0; i < 600; i++) begin
            r_sel  = int'($urandom_range(0, 1));
            r_pick = int'($urandom_range(0, 15));
            r_clr  = (r_pick == 0);
            r_ld   = (r_pick == 1 || r_pick == 2);
            r_inc  = ($urandom_range(0, 3) != 0);
            r_dec  = ($urandom_range(0, 4) == 0);
            r_lv   = {$urandom, $urandom};
            if (r_pick == 3 && !r_inc) r_dec = 1'b1;
            step(r_sel, r_clr, r_ld, r_lv, r_inc, r_dec);
            if (i == 300) async_reset_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
